// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first read bypass and a
// per-register busy scoreboard for issue/writeback of the out-of-order core.
module regfile_mp #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 4,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]       rd_busy,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*WIDTH-1:0] wr_data,
   input  logic                    alloc_en,
   input  logic [AW-1:0]           alloc_addr,
   output logic [DEPTH-1:0]        busy_vec
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Out-of-range addresses and (optionally) r0 neither store nor read back.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Ascending port order lets the highest-index writer win; allocate last so it beats writeback.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         if (wr_en[i] && addr_ok(wr_addr[i*AW +: AW])) begin
            mem_d[wr_addr[i*AW +: AW]]  = wr_data[i*WIDTH +: WIDTH];
            busy_d[wr_addr[i*AW +: AW]] = 1'b0;
         end
      end
      if (alloc_en && addr_ok(alloc_addr)) begin
         busy_d[alloc_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            mem_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   // Bypass ignores reset so a writer is visible even while reset is held.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         if (addr_ok(rd_addr[j*AW +: AW])) begin
            rd_data[j*WIDTH +: WIDTH] = mem_q[rd_addr[j*AW +: AW]];
            rd_busy[j]                = busy_q[rd_addr[j*AW +: AW]];
            for (int unsigned i = 0; i < NUM_WR; i++) begin
               if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW])) begin
                  rd_data[j*WIDTH +: WIDTH] = wr_data[i*WIDTH +: WIDTH];
                  rd_busy[j]                = 1'b0;
               end
            end
         end
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_mp;
   localparam int WIDTH  = 32;
   localparam int DEPTH  = 32;
   localparam int NUM_RD = 4;
   localparam int NUM_WR = 2;
   localparam int AW     = 5;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NUM_RD*AW-1:0]    rd_addr;
   logic [NUM_RD*WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]       rd_busy;
   logic [NUM_WR-1:0]       wr_en;
   logic [NUM_WR*AW-1:0]    wr_addr;
   logic [NUM_WR*WIDTH-1:0] wr_data;
   logic                    alloc_en;
   logic [AW-1:0]           alloc_addr;
   logic [DEPTH-1:0]        busy_vec;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] m_mem  [DEPTH];
   bit               m_busy [DEPTH];

   always #5 clk = ~clk;

   regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
   );

   // Reference model: what a read should see given stored state and this cycle's writers.
   function automatic logic [WIDTH-1:0] exp_data(input int a);
      if (a == 0) return '0;
      for (int i = NUM_WR - 1; i >= 0; i--)
         if (wr_en[i] && int'(wr_addr[i*AW +: AW]) == a) return wr_data[i*WIDTH +: WIDTH];
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input int a);
      if (a == 0) return 1'b0;
      for (int i = 0; i < NUM_WR; i++)
         if (wr_en[i] && int'(wr_addr[i*AW +: AW]) == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [DEPTH-1:0] exp_vec();
      logic [DEPTH-1:0] v;
      v = '0;
      for (int r = 0; r < DEPTH; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic model_edge();
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_WR; i++) begin
            int a;
            a = int'(wr_addr[i*AW +: AW]);
            if (wr_en[i] && a != 0) begin
               m_mem[a]  = wr_data[i*WIDTH +: WIDTH];
               m_busy[a] = 1'b0;
            end
         end
         if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
      alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
   endtask

   task automatic wr(input int p, input int a, input logic [WIDTH-1:0] d);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*WIDTH +: WIDTH] = d;
   endtask

   task automatic rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         for (int p = 0; p < NUM_RD; p++) rd(p, a);
         #2;
         for (int p = 0; p < NUM_RD; p++) begin
            total++;
            if (rd_data[p*WIDTH +: WIDTH] !== '0 || rd_busy[p] !== 1'b0) begin
               bad++;
               $display("FAIL reset_read a=%0d p=%0d got=%0h/%0b want=0/0", a, p, rd_data[p*WIDTH +: WIDTH], rd_busy[p]);
            end
         end
         tick();
      end
      total++;
      if (busy_vec !== '0) begin
         bad++; $display("FAIL reset_busy_vec got=%0h want=0", busy_vec);
      end
      idle();
      wr(0, 0, 32'd400);
      rd(0, 0);
      #2;
      total++;
      if (rd_data[0 +: WIDTH] !== '0) begin
         bad++; $display("FAIL zero_reg_bypass got=%0h want=0", rd_data[0 +: WIDTH]);
      end
      tick();
      wr_en = '0;
      #2;
      total++;
      if (rd_data[0 +: WIDTH] !== '0) begin
         bad++; $display("FAIL zero_reg_stored got=%0h want=0", rd_data[0 +: WIDTH]);
      end
      tick();
   endtask

   task automatic test_basic();
      idle();
      wr(0, 1, 32'd1); wr(1, 2, 32'd2);
      rd(0, 1); rd(1, 2);
      #2;
      total++;
      if (rd_data[0 +: WIDTH] !== 32'd1 || rd_data[WIDTH +: WIDTH] !== 32'd2) begin
         bad++; $display("FAIL basic_bypass got=%0h/%0h want=1/2", rd_data[0 +: WIDTH], rd_data[WIDTH +: WIDTH]);
      end
      tick();
      wr_en = '0;
      #2;
      total++;
      if (rd_data[0 +: WIDTH] !== 32'd1 || rd_data[WIDTH +: WIDTH] !== 32'd2) begin
         bad++; $display("FAIL basic_stored got=%0h/%0h want=1/2", rd_data[0 +: WIDTH], rd_data[WIDTH +: WIDTH]);
      end
      tick();
      idle();
      wr(0, 31, 32'd31);
      tick();
      wr_en = '0;
      for (int p = 0; p < NUM_RD; p++) rd(p, 31);
      #2;
      for (int p = 0; p < NUM_RD; p++) begin
         total++;
         if (rd_data[p*WIDTH +: WIDTH] !== 32'd31) begin
            bad++; $display("FAIL basic_r31 p=%0d got=%0h want=1f", p, rd_data[p*WIDTH +: WIDTH]);
         end
      end
      tick();
   endtask

   task automatic test_conflict();
      idle();
      wr(0, 5, 32'hAAAA); wr(1, 5, 32'h5555);
      rd(2, 5);
      #2;
      total++;
      if (rd_data[2*WIDTH +: WIDTH] !== 32'h5555) begin
         bad++; $display("FAIL conflict_bypass got=%0h want=5555", rd_data[2*WIDTH +: WIDTH]);
      end
      tick();
      wr_en = '0;
      #2;
      total++;
      if (rd_data[2*WIDTH +: WIDTH] !== 32'h5555) begin
         bad++; $display("FAIL conflict_stored got=%0h want=5555", rd_data[2*WIDTH +: WIDTH]);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      idle();
      alloc_en = 1'b1; alloc_addr = 5'd7;
      rd(1, 7);
      #2;
      total++;
      if (rd_busy[1] !== 1'b0) begin
         bad++; $display("FAIL alloc_same_cycle got=%0b want=0", rd_busy[1]);
      end
      tick();
      alloc_en = 1'b0;
      #2;
      total++;
      if (rd_busy[1] !== 1'b1 || busy_vec[7] !== 1'b1) begin
         bad++; $display("FAIL alloc_visible got=%0b/%0b want=1/1", rd_busy[1], busy_vec[7]);
      end
      wr(1, 7, 32'h77);
      #2;
      total++;
      if (rd_busy[1] !== 1'b0 || rd_data[WIDTH +: WIDTH] !== 32'h77 || busy_vec[7] !== 1'b1) begin
         bad++; $display("FAIL writeback_bypass got=%0b/%0h/%0b want=0/77/1", rd_busy[1], rd_data[WIDTH +: WIDTH], busy_vec[7]);
      end
      tick();
      wr_en = '0;
      #2;
      total++;
      if (busy_vec[7] !== 1'b0 || rd_busy[1] !== 1'b0) begin
         bad++; $display("FAIL writeback_clear got=%0b/%0b want=0/0", busy_vec[7], rd_busy[1]);
      end
      tick();
   endtask

   task automatic test_collision();
      idle();
      alloc_en = 1'b1; alloc_addr = 5'd9;
      wr(0, 9, 32'h99);
      rd(3, 9);
      tick();
      idle();
      rd(3, 9);
      #2;
      total++;
      if (rd_data[3*WIDTH +: WIDTH] !== 32'h99 || rd_busy[3] !== 1'b1 || busy_vec[9] !== 1'b1) begin
         bad++; $display("FAIL alloc_write_collision got=%0h/%0b/%0b want=99/1/1", rd_data[3*WIDTH +: WIDTH], rd_busy[3], busy_vec[9]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      idle();
      wr(0, 3, 32'h33);
      alloc_en = 1'b1; alloc_addr = 5'd3;
      tick();
      idle();
      reset = 1'b1;
      wr(1, 4, 32'h44);
      alloc_en = 1'b1; alloc_addr = 5'd4;
      rd(0, 3); rd(1, 4);
      #2;
      total++;
      if (rd_data[0 +: WIDTH] !== 32'h33 || rd_busy[0] !== 1'b1 || rd_data[WIDTH +: WIDTH] !== 32'h44) begin
         bad++; $display("FAIL reset_mid_before got=%0h/%0b/%0h want=33/1/44", rd_data[0 +: WIDTH], rd_busy[0], rd_data[WIDTH +: WIDTH]);
      end
      tick();
      reset = 1'b0; wr_en = '0; alloc_en = 1'b0;
      #2;
      total++;
      if (rd_data[0 +: WIDTH] !== '0 || rd_data[WIDTH +: WIDTH] !== '0 || busy_vec !== '0) begin
         bad++; $display("FAIL reset_mid_after got=%0h/%0h/%0h want=0/0/0", rd_data[0 +: WIDTH], rd_data[WIDTH +: WIDTH], busy_vec);
      end
      tick();
   endtask

   task automatic test_random();
      idle();
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit narrow;
         narrow = ($urandom_range(0, 1) == 1);
         reset = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < NUM_WR; i++) begin
            wr_en[i] = ($urandom_range(0, 2) != 0);
            wr_addr[i*AW +: AW] = AW'(narrow ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
            wr_data[i*WIDTH +: WIDTH] = $urandom;
         end
         alloc_en = ($urandom_range(0, 1) == 1);
         alloc_addr = AW'(narrow ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
         for (int p = 0; p < NUM_RD; p++)
            rd(p, narrow ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
         #2;
         for (int p = 0; p < NUM_RD; p++) begin
            int a;
            a = int'(rd_addr[p*AW +: AW]);
            total++;
            if (rd_data[p*WIDTH +: WIDTH] !== exp_data(a) || rd_busy[p] !== exp_busy(a)) begin
               bad++;
               $display("FAIL random_read cyc=%0d p=%0d a=%0d got=%0h/%0b want=%0h/%0b",
                        cyc, p, a, rd_data[p*WIDTH +: WIDTH], rd_busy[p], exp_data(a), exp_busy(a));
            end
         end
         total++;
         if (busy_vec !== exp_vec()) begin
            bad++; $display("FAIL random_busy_vec cyc=%0d got=%0h want=%0h", cyc, busy_vec, exp_vec());
         end
         tick();
      end
      idle();
   endtask

   initial begin
      for (int r = 0; r < DEPTH; r++) begin
         m_mem[r]  = '0;
         m_busy[r] = 1'b0;
      end
      idle();
      #1;
      test_reset();
      test_basic();
      test_conflict();
      test_scoreboard();
      test_collision();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
